// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_ctrl_pkg
// Description : Shared types and constants for the PE sequencer: the
//               sequencer state enum, the accumulator lane count and the
//               number of psum cycles appended to a job.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_ctrl_pkg;

    // Sequencer states.
    //   S_UNCFG : no config loaded, accepting a new one
    //   S_WAIT  : config loaded, waiting for operands/space/psums
    //   S_ISSUE : operand pops in progress (k = 1..2T)
    //   S_TAIL  : multiplier drain, optional psum add and result drive
    typedef enum logic [1:0] {
        S_UNCFG = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_TAIL  = 2'd3
    } pe_seq_state_e;

    // The PE accumulator feedback loop is two deep, so every job carries
    // two interleaved sums (lane 0 and lane 1).
    localparam int unsigned c_num_lanes = 2;

    // One upstream psum is added per lane after the taps.
    localparam int unsigned c_psum_tail = 2;

endpackage
`default_nettype wire

// File: rtl/pe_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_seq_ctrl_if
// Description : Config handshake, FIFO status/pop and PE select signals
//               between the array scheduler and the PE sequencer.
//               slave  : the sequencer side
//               master : the scheduler / FIFO / PE side
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_seq_ctrl_if #(
    parameter int TAP_W = 8,
    parameter int JOB_W = 16
);
    // Config handshake
    logic             cfg_valid;
    logic             cfg_ready;
    logic [TAP_W-1:0] cfg_taps;
    logic [JOB_W-1:0] cfg_jobs;
    logic             cfg_psum_en;

    // FIFO status and pops
    logic             op_avail;
    logic             op_rd;
    logic             psum_avail;
    logic             psum_rd;
    logic             out_space;

    // PE control and result qualification
    logic             out_valid;
    logic             out_lane;
    logic             mult_seln;
    logic             acc_seln;

    // Status
    logic             busy;
    logic             done;
    logic             cfg_err;

    modport slave (
        input  cfg_valid, cfg_taps, cfg_jobs, cfg_psum_en,
        input  op_avail, psum_avail, out_space,
        output cfg_ready, op_rd, psum_rd, out_valid, out_lane,
        output mult_seln, acc_seln, busy, done, cfg_err
    );

    modport master (
        output cfg_valid, cfg_taps, cfg_jobs, cfg_psum_en,
        output op_avail, psum_avail, out_space,
        input  cfg_ready, op_rd, psum_rd, out_valid, out_lane,
        input  mult_seln, acc_seln, busy, done, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pe_seq_ctrl
// Description : Sequencer for one processing element. Accepts a job config
//               (tap count, job count, psum enable) and, per job, pops the
//               operand/psum FIFOs and drives the PE addend select and
//               feedback clear so the PE produces two interleaved sums.
//               All outputs come straight from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_seq_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int TAP_W    = 8,
    parameter int JOB_W    = 16,
    parameter int MULT_LAT = 2
) (
    input  logic         clk,
    input  logic         rstn,
    pe_seq_ctrl_if.slave bus
);

    // Position-in-job counter width: holds 2*(2^TAP_W-1) + MULT_LAT + 2.
    localparam int c_k_w = TAP_W + 3;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    pe_seq_state_e    state_q,     state_d;
    logic [c_k_w-1:0] k_q,         k_d;
    logic [JOB_W-1:0] jobs_q,      jobs_d;
    logic [TAP_W-1:0] taps_q,      taps_d;
    logic             psum_en_q,   psum_en_d;
    logic             cfg_err_q,   cfg_err_d;
    logic             done_q,      done_d;

    logic             cfg_ready_q, cfg_ready_d;
    logic             busy_q,      busy_d;
    logic             op_rd_q,     op_rd_d;
    logic             psum_rd_q,   psum_rd_d;
    logic             mult_seln_q, mult_seln_d;
    logic             acc_seln_q,  acc_seln_d;
    logic             out_valid_q, out_valid_d;
    logic             out_lane_q,  out_lane_d;

    // ------------------------------------------------------------------
    // Job phase boundaries derived from the latched config
    // ------------------------------------------------------------------
    logic [c_k_w-1:0] w_issue_end;   // last operand pop, k = 2T
    logic [c_k_w-1:0] w_mult_lo;     // first product at the PE, k = L+1
    logic [c_k_w-1:0] w_mult_hi;     // last product at the PE, k = 2T+L
    logic [c_k_w-1:0] w_job_end;     // E, final cycle of the job
    logic             w_start;
    logic             w_run_d;

    assign w_issue_end = c_k_w'(taps_q) * c_k_w'(c_num_lanes);
    assign w_mult_lo   = c_k_w'(MULT_LAT) + c_k_w'(1);
    assign w_mult_hi   = w_issue_end + c_k_w'(MULT_LAT);
    assign w_job_end   = psum_en_q ? (w_mult_hi + c_k_w'(c_psum_tail)) : w_mult_hi;

    // A job may only start when it can run to completion without a stall:
    // the PE has no enable, so every resource is checked up front.
    assign w_start = bus.op_avail && bus.out_space &&
                     (!psum_en_q || bus.psum_avail);

    // Next-state logic: config capture, job start, k advance, job count.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        jobs_d    = jobs_q;
        taps_d    = taps_q;
        psum_en_d = psum_en_q;
        cfg_err_d = cfg_err_q;
        done_d    = 1'b0;

        case (state_q)
            S_UNCFG: begin
                if (bus.cfg_valid) begin
                    if ((bus.cfg_taps == '0) || (bus.cfg_jobs == '0)) begin
                        // Degenerate config: flag it and stay unconfigured.
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        taps_d    = bus.cfg_taps;
                        jobs_d    = bus.cfg_jobs;
                        psum_en_d = bus.cfg_psum_en;
                        k_d       = '0;
                        state_d   = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (w_start) begin
                    k_d     = c_k_w'(1);
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                k_d = k_q + c_k_w'(1);
                if (k_q == w_issue_end) begin
                    state_d = S_TAIL;
                end
            end

            S_TAIL: begin
                if (k_q == w_job_end) begin
                    k_d    = '0;
                    jobs_d = jobs_q - JOB_W'(1);
                    if (jobs_q == JOB_W'(1)) begin
                        state_d = S_UNCFG;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    k_d = k_q + c_k_w'(1);
                end
            end

            default: begin
                state_d = S_UNCFG;
                k_d     = '0;
            end
        endcase
    end

    // Output decode from the next state, so every output leaves a flop.
    // taps_q/psum_en_q are stable whenever the next state is a run state,
    // because they only change on the UNCFG -> WAIT transition.
    always_comb begin
        w_run_d     = (state_d == S_ISSUE) || (state_d == S_TAIL);
        cfg_ready_d = (state_d == S_UNCFG);
        busy_d      = (state_d != S_UNCFG);
        op_rd_d     = (state_d == S_ISSUE);
        mult_seln_d = w_run_d && (k_d >= w_mult_lo) && (k_d <= w_mult_hi);
        // Keep the feedback cleared until the first product of each lane
        // has entered the loop.
        acc_seln_d  = !w_run_d || (k_d <= w_mult_lo);
        psum_rd_d   = w_run_d && psum_en_q &&
                      ((k_d == w_mult_hi + c_k_w'(1)) ||
                       (k_d == w_mult_hi + c_k_w'(2)));
        out_valid_d = w_run_d &&
                      ((k_d == w_job_end - c_k_w'(1)) || (k_d == w_job_end));
        out_lane_d  = w_run_d && (k_d == w_job_end);
    end

    // Sequencer state and output registers; reset abandons any job at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_UNCFG;
            k_q         <= '0;
            jobs_q      <= '0;
            taps_q      <= '0;
            psum_en_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            op_rd_q     <= 1'b0;
            psum_rd_q   <= 1'b0;
            mult_seln_q <= 1'b0;
            acc_seln_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_lane_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            jobs_q      <= jobs_d;
            taps_q      <= taps_d;
            psum_en_q   <= psum_en_d;
            cfg_err_q   <= cfg_err_d;
            done_q      <= done_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            op_rd_q     <= op_rd_d;
            psum_rd_q   <= psum_rd_d;
            mult_seln_q <= mult_seln_d;
            acc_seln_q  <= acc_seln_d;
            out_valid_q <= out_valid_d;
            out_lane_q  <= out_lane_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.busy      = busy_q;
    assign bus.op_rd     = op_rd_q;
    assign bus.psum_rd   = psum_rd_q;
    assign bus.mult_seln = mult_seln_q;
    assign bus.acc_seln  = acc_seln_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_lane  = out_lane_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_seq_ctrl
// Description : Self-checking bench for pe_seq_ctrl. A job-level reference
//               model predicts the control outputs from the position in the
//               job; a behavioural PE with operand/psum FIFOs turns the
//               DUT's selects into sums compared against plain lane sums.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pe_seq_ctrl;

    localparam int TAP_W = 8;
    localparam int JOB_W = 16;
    localparam int L     = 2;
    // {cfg_ready,busy,op_rd,psum_rd,mult_seln,acc_seln,out_valid,out_lane,done,cfg_err}
    localparam logic [9:0] RST_VEC = 10'b1000010000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pe_seq_ctrl_if #(.TAP_W(TAP_W), .JOB_W(JOB_W)) bus ();

    pe_seq_ctrl #(.TAP_W(TAP_W), .JOB_W(JOB_W), .MULT_LAT(L)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Environment: FIFOs and expected results
    int op_a[$], op_w[$], ps_q[$], exp_res[$];
    bit op_block = 0, rand_space = 0;
    int done_cnt = 0;

    // Job-level reference model (m_k = 0 means waiting, 1..E inside a job)
    bit m_busy, m_psum, m_err, m_done;
    int m_k, m_t, m_jobs;

    // Behavioural PE
    int pipe[$];
    int mac1, mac2;
    bit acc_prev;

    logic [9:0] exp_vec, obs_vec;
    bit got_res;
    int res_val, res_exp;

    task automatic model_reset();
        m_busy = 0; m_psum = 0; m_err = 0; m_done = 0;
        m_k = 0; m_t = 1; m_jobs = 0;
        op_a.delete(); op_w.delete(); ps_q.delete(); exp_res.delete();
        pipe.delete();
        repeat (L) pipe.push_back(0);
        mac1 = 0; mac2 = 0; acc_prev = 1;
    endtask

    function automatic int job_len();
        return 2 * m_t + L + (m_psum ? 2 : 0);
    endfunction

    function automatic logic [9:0] model_out();
        logic [9:0] v;
        bit run;
        int e;
        run = m_busy && (m_k > 0);
        e   = job_len();
        v[9] = !m_busy;
        v[8] = m_busy;
        v[7] = run && (m_k <= 2 * m_t);
        v[6] = run && m_psum && (m_k > 2 * m_t + L);
        v[5] = run && (m_k > L) && (m_k <= 2 * m_t + L);
        v[4] = !run || (m_k <= L + 1);
        v[3] = run && (m_k >= e - 1);
        v[2] = run && (m_k == e);
        v[1] = m_done;
        v[0] = m_err;
        return v;
    endfunction

    task automatic model_step();
        bit nd;
        nd = 0;
        if (!m_busy) begin
            if (bus.cfg_valid) begin
                if (bus.cfg_taps == 0 || bus.cfg_jobs == 0) m_err = 1;
                else begin
                    m_err = 0; m_busy = 1; m_k = 0;
                    m_t = int'(bus.cfg_taps); m_jobs = int'(bus.cfg_jobs);
                    m_psum = bus.cfg_psum_en;
                end
            end
        end else if (m_k == 0) begin
            if (bus.op_avail && bus.out_space && (!m_psum || bus.psum_avail)) m_k = 1;
        end else if (m_k == job_len()) begin
            m_jobs--; m_k = 0;
            if (m_jobs == 0) begin m_busy = 0; nd = 1; end
        end else begin
            m_k++;
        end
        m_done = nd;
    endtask

    // One clock: sample at negedge, run PE + model, drive FIFO status after posedge.
    task automatic cycle();
        int prod, add_p, fb, mac, ph;
        @(negedge clk);
        if (!rstn) model_reset();
        exp_vec = model_out();
        obs_vec = {bus.cfg_ready, bus.busy, bus.op_rd, bus.psum_rd, bus.mult_seln,
                   bus.acc_seln, bus.out_valid, bus.out_lane, bus.done, bus.cfg_err};
        if (bus.done === 1'b1) done_cnt++;
        prod = 0;
        if (bus.op_rd === 1'b1 && op_a.size() > 0) prod = op_a.pop_front() * op_w.pop_front();
        pipe.push_back(prod);
        add_p = pipe.pop_front();
        ph = (ps_q.size() > 0) ? ps_q[0] : 0;
        fb = acc_prev ? 0 : mac2;
        mac = fb + ((bus.mult_seln === 1'b1) ? add_p : ph);
        mac2 = mac1; mac1 = mac;
        acc_prev = (bus.acc_seln !== 1'b0);
        if (bus.psum_rd === 1'b1 && ps_q.size() > 0) void'(ps_q.pop_front());
        got_res = (bus.out_valid === 1'b1);
        if (got_res) begin
            res_val = mac;
            res_exp = (exp_res.size() > 0) ? exp_res.pop_front() : -1;
        end
        if (rstn) model_step();
        @(posedge clk); #1;
        bus.op_avail   = !op_block && (op_a.size() >= 2 * m_t);
        bus.psum_avail = (ps_q.size() >= 2);
        bus.out_space  = rand_space ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Queue one job's operands/psums and its two expected lane sums.
    task automatic load_job(input int t, input bit ps, input bit fixed);
        int s0, s1, a, w;
        s0 = 0; s1 = 0;
        for (int i = 0; i < 2 * t; i++) begin
            a = fixed ? i + 1 : int'($urandom_range(0, 255));
            w = fixed ? 2     : int'($urandom_range(0, 255));
            op_a.push_back(a); op_w.push_back(w);
            if (i % 2 == 0) s0 += a * w; else s1 += a * w;
        end
        if (ps) begin
            a = fixed ? 100 : int'($urandom_range(0, 10000));
            w = fixed ? 200 : int'($urandom_range(0, 10000));
            ps_q.push_back(a); ps_q.push_back(w);
            s0 += a; s1 += w;
        end
        exp_res.push_back(s0); exp_res.push_back(s1);
    endtask

    task automatic offer_cfg(input int t, input int j, input bit ps);
        bus.cfg_valid   = 1'b1;
        bus.cfg_taps    = TAP_W'(t);
        bus.cfg_jobs    = JOB_W'(j);
        bus.cfg_psum_en = ps;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) cycle();
        checks++;
        if (obs_vec !== RST_VEC) begin errors++; $display("FAIL reset_vec got=%b exp=%b", obs_vec, RST_VEC); end
        rstn = 1'b1;
        cycle();
        checks++;
        if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_idle got=%b exp=%b", obs_vec, exp_vec); end
    endtask

    task automatic test_single();
        bit fin;
        done_cnt = 0; fin = 0;
        load_job(1, 0, 0);
        offer_cfg(1, 1, 0);
        for (int c = 0; c < 200 && !fin; c++) begin
            cycle();
            bus.cfg_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL single_ctl c=%0d got=%b exp=%b", c, obs_vec, exp_vec); end
            if (got_res) begin
                checks++;
                if (res_val !== res_exp) begin errors++; $display("FAIL single_sum got=%0d exp=%0d", res_val, res_exp); end
            end
            fin = exp_vec[1];
        end
        checks++;
        if (!fin || done_cnt != 1) begin errors++; $display("FAIL single_done pulses=%0d exp=1", done_cnt); end
    endtask

    task automatic test_psum_fixed();
        bit fin;
        int r[2];
        int n;
        fin = 0; n = 0;
        load_job(3, 1, 1);
        offer_cfg(3, 1, 1);
        for (int c = 0; c < 200 && !fin; c++) begin
            cycle();
            bus.cfg_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL psum_ctl c=%0d got=%b exp=%b", c, obs_vec, exp_vec); end
            if (got_res && n < 2) begin r[n] = res_val; n++; end
            fin = exp_vec[1];
        end
        checks++;
        if (n != 2 || r[0] != 118 || r[1] != 224) begin
            errors++; $display("FAIL psum_sums got=%0d,%0d exp=118,224", r[0], r[1]);
        end
    endtask

    task automatic test_stall();
        bit fin;
        int t, blk;
        bit ps;
        fin = 0; blk = 0; done_cnt = 0;
        t = int'($urandom_range(1, 4)); ps = 1'($urandom_range(0, 1));
        repeat (3) load_job(t, ps, 0);
        offer_cfg(t, 3, ps);
        for (int c = 0; c < 600 && !fin; c++) begin
            cycle();
            bus.cfg_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL stall_ctl c=%0d got=%b exp=%b", c, obs_vec, exp_vec); end
            if (got_res) begin
                checks++;
                if (res_val !== res_exp) begin errors++; $display("FAIL stall_sum got=%0d exp=%0d", res_val, res_exp); end
            end
            if (op_block) begin blk++; if (blk >= 6) op_block = 0; end
            if (m_busy && m_jobs == 3 && m_k == job_len()) begin op_block = 1; blk = 0; end
            fin = exp_vec[1];
        end
        checks++;
        if (!fin || done_cnt != 1) begin errors++; $display("FAIL stall_done pulses=%0d exp=1", done_cnt); end
    endtask

    task automatic test_cfg_err();
        bit fin;
        fin = 0;
        offer_cfg(0, 5, 0);
        cycle();
        bus.cfg_valid = 1'b0;
        cycle();
        checks++;
        if (obs_vec[0] !== 1'b1 || obs_vec[8] !== 1'b0) begin
            errors++; $display("FAIL err_t0 err=%b busy=%b exp err=1 busy=0", obs_vec[0], obs_vec[8]);
        end
        offer_cfg(3, 0, 0);
        cycle();
        bus.cfg_valid = 1'b0;
        cycle();
        checks++;
        if (obs_vec !== exp_vec || obs_vec[0] !== 1'b1) begin errors++; $display("FAIL err_j0 got=%b exp=%b", obs_vec, exp_vec); end
        load_job(2, 0, 0);
        offer_cfg(2, 1, 0);
        for (int c = 0; c < 200 && !fin; c++) begin
            cycle();
            bus.cfg_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL err_clr c=%0d got=%b exp=%b", c, obs_vec, exp_vec); end
            fin = exp_vec[1];
        end
        checks++;
        if (obs_vec[0] !== 1'b0) begin errors++; $display("FAIL err_cleared err=%b exp=0", obs_vec[0]); end
    endtask

    task automatic test_reset_mid();
        bit fin, hit;
        fin = 0; hit = 0;
        load_job(4, 0, 0);
        offer_cfg(4, 1, 0);
        for (int c = 0; c < 100 && !hit; c++) begin
            cycle();
            bus.cfg_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL rmid_ctl c=%0d got=%b exp=%b", c, obs_vec, exp_vec); end
            hit = (m_k == 4);
        end
        rstn = 1'b0;
        cycle();
        checks++;
        if (!hit || obs_vec !== RST_VEC) begin errors++; $display("FAIL rmid_reset got=%b exp=%b", obs_vec, RST_VEC); end
        rstn = 1'b1;
        load_job(2, 1, 0);
        offer_cfg(2, 1, 1);
        for (int c = 0; c < 200 && !fin; c++) begin
            cycle();
            bus.cfg_valid = 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL rmid_rerun c=%0d got=%b exp=%b", c, obs_vec, exp_vec); end
            if (got_res) begin
                checks++;
                if (res_val !== res_exp) begin errors++; $display("FAIL rmid_sum got=%0d exp=%0d", res_val, res_exp); end
            end
            fin = exp_vec[1];
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL rmid_timeout done=0 exp=1"); end
    endtask

    task automatic test_cfg_busy();
        bit fin;
        int t;
        fin = 0;
        t = int'($urandom_range(2, 6));
        load_job(t, 1, 0);
        offer_cfg(t, 1, 1);
        cycle();
        bus.cfg_valid = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (m_busy && m_k == 1) offer_cfg(0, 0, 0);
            if (m_k > 2 * m_t) bus.cfg_valid = 1'b0;
            cycle();
            checks++;
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL busy_ctl c=%0d got=%b exp=%b", c, obs_vec, exp_vec); end
            if (got_res) begin
                checks++;
                if (res_val !== res_exp) begin errors++; $display("FAIL busy_sum got=%0d exp=%0d", res_val, res_exp); end
            end
            fin = exp_vec[1];
        end
        bus.cfg_valid = 1'b0;
        checks++;
        if (!fin || obs_vec[0] !== 1'b0) begin errors++; $display("FAIL busy_err err=%b exp=0", obs_vec[0]); end
    endtask

    // Back-to-back random configs; each next config is offered in the done cycle.
    task automatic test_back_to_back();
        bit fin;
        int t, j;
        bit ps;
        rand_space = 1;
        for (int it = 0; it < 6; it++) begin
            fin = 0;
            t  = (it == 3) ? 255 : int'($urandom_range(1, 6));
            j  = int'($urandom_range(1, 3));
            ps = 1'($urandom_range(0, 1));
            repeat (j) load_job(t, ps, 0);
            offer_cfg(t, j, ps);
            for (int c = 0; c < 4000 && !fin; c++) begin
                cycle();
                bus.cfg_valid = 1'b0;
                checks++;
                if (obs_vec !== exp_vec) begin errors++; $display("FAIL b2b_ctl it=%0d c=%0d got=%b exp=%b", it, c, obs_vec, exp_vec); end
                if (got_res) begin
                    checks++;
                    if (res_val !== res_exp) begin errors++; $display("FAIL b2b_sum it=%0d got=%0d exp=%0d", it, res_val, res_exp); end
                end
                fin = m_done;
            end
            checks++;
            if (!fin) begin errors++; $display("FAIL b2b_timeout it=%0d", it); end
        end
        rand_space = 0;
        cycle();
        checks++;
        if (obs_vec !== exp_vec || obs_vec[1] !== 1'b1) begin errors++; $display("FAIL b2b_last got=%b exp=%b", obs_vec, exp_vec); end
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_taps = '0; bus.cfg_jobs = '0; bus.cfg_psum_en = 1'b0;
        bus.op_avail = 1'b0; bus.psum_avail = 1'b0; bus.out_space = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_psum_fixed();
        test_stall();
        test_cfg_err();
        test_reset_mid();
        test_cfg_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
